seg7_mux_counter: RTL and testbench



---
 rtl/seg7_mux_counter.sv | 203 ++++++++++++++++++++
 tb/tb_seg7_mux_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_counter.sv
// rtl/seg7_mux_counter.sv - multi-digit BCD/hex up/down counter with multiplexed 7-segment driver
//
// Purpose:
//   N-digit up/down counter advanced by a prescaled tick, with synchronous load.
//   Drives a time-multiplexed 7-segment display. Each digit slot starts with one
//   blank cycle so the previous digit's segments do not ghost onto the next digit.
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (k>0) show no segments.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   en       in   count enable; gates the tick prescaler
//   up       in   1 = increment, 0 = decrement on each tick
//   load     in   synchronous load of load_val (clamped to 9 per digit in BCD mode)
//   load_val in   packed digits, [3:0] = digit 0
//   count    out  registered count value
//   wrap     out  one-cycle pulse on count wrap-around
//   seg      out  segments, seg[0]=a .. seg[6]=g
//   dig_sel  out  digit enables, one-hot or all inactive
module seg7_mux_counter #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 4194304,
  parameter int SCAN_DIV       = 16384,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]         SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]            DIGIT_MAX  = (HEX_MODE != 0) ? 4'hF : 4'h9;
  localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  // Active-high gfedcba glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]           scan_idx_q, scan_idx_d;
  logic                    wrap_q, wrap_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;

  logic                    tick;
  logic                    carry;
  logic [4*NUM_DIGITS-1:0] stepped;
  logic [4*NUM_DIGITS-1:0] load_clamped;
  logic [3:0]              cur_digit;
  logic                    blank_digit;
  logic [6:0]              glyph_raw;
  logic [NUM_DIGITS-1:0]   onehot;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                    hi_zero;
`endif

  always_comb begin
    tick = en && (presc_q == PRESC_LAST);

    load_clamped = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((HEX_MODE == 0) && (load_val[4*i +: 4] > 4'd9)) begin
        load_clamped[4*i +: 4] = 4'd9;
      end
    end

    // Ripple increment/decrement; carry doubles as borrow. A carry out of the
    // top digit means every digit wrapped, which is exactly the wrap condition.
    carry   = 1'b1;
    stepped = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (count_q[4*i +: 4] == DIGIT_MAX) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = DIGIT_MAX;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end

    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      // Load wins over a same-cycle tick and restarts the tick period.
      count_d = load_clamped;
      presc_d = '0;
    end else begin
      if (en) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        count_d = stepped;
        wrap_d  = carry;
      end
    end

    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end

    cur_digit   = count_q[{scan_idx_q, 2'b00} +: 4];
    blank_digit = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; hi_zero holds "this digit and all above are 0".
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero = hi_zero && (count_q[4*i +: 4] == 4'd0);
      if (scan_idx_q == IW'(i)) begin
        blank_digit = hi_zero;
      end
    end
`endif

    // Scan-counter value 0 is the anti-ghost gap: no digit, no segments.
    onehot    = '0;
    glyph_raw = 7'h00;
    if (scan_cnt_q != '0) begin
      onehot[scan_idx_q] = 1'b1;
      if (!blank_digit) begin
        glyph_raw = glyph(cur_digit);
      end
    end
    seg_d     = (SEG_ACTIVE_LOW != 0) ? ~glyph_raw : glyph_raw;
    dig_sel_d = (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_sel_q  <= DIG_OFF;
    end else begin
      count_q    <= count_d;
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      wrap_q     <= wrap_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// tb/tb_seg7_mux_counter.sv - directed self-checking bench for seg7_mux_counter
module tb_seg7_mux_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] b_count;
  logic       b_wrap;
  logic [6:0] b_seg;
  logic [1:0] b_dig;

  logic [7:0] h_count;
  logic       h_wrap;
  logic [6:0] h_seg;
  logic [1:0] h_dig;

  int checks = 0;
  int errors = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  seg7_mux_counter #(
    .NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .HEX_MODE(0),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_bcd (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(b_count), .wrap(b_wrap), .seg(b_seg), .dig_sel(b_dig)
  );

  seg7_mux_counter #(
    .NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .HEX_MODE(1),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_hex (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(h_count), .wrap(h_wrap), .seg(h_seg), .dig_sel(h_dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset, then load ldv with en=0 on the first edge and follow six edges of
  // scanning. s0/s1 are the expected segments while digit 0/1 is selected.
  task automatic scan_check(input string tag, input logic [7:0] ldv,
                            input logic [6:0] b_s0, input logic [6:0] b_s1,
                            input logic [6:0] h_s0, input logic [6:0] h_s1);
    logic [1:0] exp_dig [6];
    exp_dig = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01};
    rst = 1'b1; load = 1'b1; load_val = ldv; en = 1'b1;
    step(1);
    check({tag, "_rst_over_load"}, b_count, 8'h00);
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      load = 1'b0;
      check($sformatf("%s_bdig%0d", tag, i), b_dig, exp_dig[i]);
      check($sformatf("%s_hdig%0d", tag, i), h_dig, exp_dig[i]);
      if (exp_dig[i] == 2'b10) begin
        check($sformatf("%s_bseg0_%0d", tag, i), b_seg, b_s0);
        check($sformatf("%s_hseg0_%0d", tag, i), h_seg, h_s0);
      end else if (exp_dig[i] == 2'b01) begin
        check($sformatf("%s_bseg1_%0d", tag, i), b_seg, b_s1);
        check($sformatf("%s_hseg1_%0d", tag, i), h_seg, h_s1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;

    // Reset state
    step(2);
    check("rst_count", b_count, 8'h00);
    check("rst_wrap", b_wrap, 1'b0);
    check("rst_seg", b_seg, 7'h7F);
    check("rst_dig", b_dig, 2'b11);
    check("rst_hcount", h_count, 8'h00);

    // First tick 4 cycles after en rises
    rst = 1'b0; en = 1'b1;
    step(3);
    check("first_tick_early", b_count, 8'h00);
    step(1);
    check("first_tick", b_count, 8'h01);

    // BCD up: 09 -> 10
    load = 1'b1; load_val = 8'h09;
    step(1);
    load = 1'b0;
    check("load09", b_count, 8'h09);
    step(3);
    check("up09_hold", b_count, 8'h09);
    step(1);
    check("up09_to_10", b_count, 8'h10);

    // BCD up wrap: 99 -> 00, one-cycle wrap
    load = 1'b1; load_val = 8'h99;
    step(1);
    load = 1'b0;
    check("load99_nowrap", b_wrap, 1'b0);
    step(3);
    check("pre_wrap", b_wrap, 1'b0);
    step(1);
    check("up99_to_00", b_count, 8'h00);
    check("up_wrap_pulse", b_wrap, 1'b1);
    step(1);
    check("up_wrap_clear", b_wrap, 1'b0);

    // BCD down wrap: 00 -> 99
    up = 1'b0; load = 1'b1; load_val = 8'h00;
    step(1);
    load = 1'b0;
    step(4);
    check("dn00_to_99", b_count, 8'h99);
    check("dn_wrap_pulse", b_wrap, 1'b1);
    step(1);
    check("dn_wrap_clear", b_wrap, 1'b0);

    // BCD load clamp: 3C -> 39
    load = 1'b1; load_val = 8'h3C;
    step(1);
    load = 1'b0;
    check("clamp_3C", b_count, 8'h39);
    check("hex_noclamp_3C", h_count, 8'h3C);

    // en=0 freezes prescaler mid-period
    step(2);
    en = 1'b0;
    step(10);
    check("en0_hold", b_count, 8'h39);
    en = 1'b1;
    step(1);
    check("en1_resume_early", b_count, 8'h39);
    step(1);
    check("en1_resume_tick", b_count, 8'h38);

    // Load vs tick collision
    up = 1'b1;
    step(3);
    load = 1'b1; load_val = 8'h42;
    step(1);
    load = 1'b0;
    check("collide_load", b_count, 8'h42);
    check("collide_nowrap", b_wrap, 1'b0);
    step(3);
    check("collide_hold", b_count, 8'h42);
    step(1);
    check("collide_next_tick", b_count, 8'h43);

    // Hex counting
    load = 1'b1; load_val = 8'h0F;
    step(1);
    load = 1'b0;
    check("hex_load0F", h_count, 8'h0F);
    check("bcd_clamp0F", b_count, 8'h09);
    step(4);
    check("hex_0F_to_10", h_count, 8'h10);
    load = 1'b1; load_val = 8'hFF;
    step(1);
    load = 1'b0;
    step(4);
    check("hex_FF_to_00", h_count, 8'h00);
    check("hex_wrap", h_wrap, 1'b1);
    step(1);
    check("hex_wrap_clear", h_wrap, 1'b0);

    // Scanning and glyphs
    scan_check("scan57", 8'h57, 7'h78, 7'h12, 7'h78, 7'h12);
    scan_check("scan0F", 8'h0F, 7'h10, LZ_SEG, 7'h0E, LZ_SEG);
    check("scan0F_bclamp", b_count, 8'h09);
    scan_check("scan05", 8'h05, 7'h12, LZ_SEG, 7'h12, LZ_SEG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
